// File: rtl/har_pkg.sv
`default_nettype none
// ============================================================================
// Module      : har_pkg
// Description : Shared loader state encoding, default frame geometry and an
//               index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package har_pkg;

    localparam int IMG_SIZE_DEF = 95;
    localparam int M_DEF        = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    // A single-sample frame still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/har_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : har_frame_buf
// Description : IMG_SIZE x (M+1) register array with indexed write port and a
//               flattened read-out of every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module har_frame_buf
    import har_pkg::*;
#(
    parameter int IMG_SIZE = IMG_SIZE_DEF,
    parameter int M        = M_DEF,
    parameter int IDX_W    = idx_width(IMG_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  logic [IDX_W-1:0]           i_idx,
    input  logic signed [M:0]          i_wdata,
    output logic [IMG_SIZE*(M+1)-1:0]  o_flat
);

    for (genvar g = 0; g < IMG_SIZE; g++) begin : g_row
        logic [M:0] r_word;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_word <= '0;
            end else if (i_we && (i_idx == IDX_W'(g))) begin
                r_word <= i_wdata;
            end
        end

        assign o_flat[g*(M+1) +: (M+1)] = r_word;
    end

endmodule
`default_nettype wire

// File: rtl/har_feature_loader.sv
`default_nettype none
// ============================================================================
// Module      : har_feature_loader
// Description : Assembles a streamed frame of signed feature samples and holds
//               it for the classifier until the result is acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module har_feature_loader
    import har_pkg::*;
#(
    parameter int IMG_SIZE = IMG_SIZE_DEF,
    parameter int M        = M_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic signed [M:0]          s_data,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [IMG_SIZE*(M+1)-1:0]  image_flat,
    output logic                       V_valid,
    input  logic                       res_ack,
    output logic                       err_len,
    output logic [15:0]                frame_cnt
);

    localparam int               IDX_W      = idx_width(IMG_SIZE);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(IMG_SIZE - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              r_err_len;
    logic              w_err_nxt;
    logic [15:0]       r_frame_cnt;
    logic [15:0]       w_cnt_nxt;
    logic              w_accepting;
    logic              w_xfer;
    logic              w_we;

    assign w_accepting = (r_state != ST_PRESENT) && !rst;
    assign w_xfer      = s_valid && w_accepting;
    // IDLE always restarts a frame at slot 0, whatever idx was left behind.
    assign w_wr_idx    = (r_state == ST_IDLE) ? '0 : r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_err_len   <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_err_len   <= w_err_nxt;
            r_frame_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_frame_cnt;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_xfer) begin
                    w_we = 1'b1;
                    if (w_wr_idx == c_last_idx) begin
                        w_idx_nxt = '0;
                        if (s_last) begin
                            w_state_nxt = ST_PRESENT;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end else if (s_last) begin
                        // Short frame: discard and wait for a fresh sample 0.
                        w_err_nxt   = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt   = w_wr_idx + 1'b1;
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            ST_DROP: begin
                if (w_xfer && s_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (res_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = r_frame_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    har_frame_buf #(
        .IMG_SIZE (IMG_SIZE),
        .M        (M),
        .IDX_W    (IDX_W)
    ) u_frame_buf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_idx    (w_wr_idx),
        .i_wdata  (s_data),
        .o_flat   (image_flat)
    );

    assign s_ready   = w_accepting;
    assign V_valid   = (r_state == ST_PRESENT) && !rst;
    assign err_len   = r_err_len && !rst;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
